// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: round-robin arbiter for N requesters.
// Grants are registered and handed over without a dead cycle when the
// owner releases. The most recent winner always drops to lowest priority.
// An optional hold limit (MAX_HOLD > 0) forces rotation away from an owner
// that keeps requesting while someone else is waiting.

module rr_arbiter_n #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 0,
   parameter int IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id,
   output logic           expired
);

   // Reject parameter values the scan and index widths were not built for.
   generate
      if (N < 2 || N > 32) begin : g_bad_n
         $error("rr_arbiter_n: N must be in 2..32");
      end
      if (MAX_HOLD < 0) begin : g_bad_hold
         $error("rr_arbiter_n: MAX_HOLD must not be negative");
      end
   endgenerate

   // Most recent winner; it is scanned last so it has lowest priority.
   logic [IDW-1:0] last;

   logic [IDW-1:0] winner;
   logic           found;
   logic [N-1:0]   winner_onehot;

   logic any_req;
   logic owner_req;
   logic others_req;
   logic at_limit;
   logic expire_now;
   logic take_new;
   logic go_idle;

   // Rotating priority scan: start just after last and wrap round so that
   // last itself is checked at the very end (a sole requester can win again).
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = 1; i <= N; i++) begin
         if (!found && req[(int'(last) + i) % N]) begin
            found  = 1'b1;
            winner = IDW'((int'(last) + i) % N);
         end
      end
   end

   // Decode the winner index into the one-hot grant pattern.
   always_comb begin
      winner_onehot = '0;
      winner_onehot[winner] = 1'b1;
   end

   // Grant decision: keep, hand over (release or hold-limit), or go idle.
   // When the owner is still requesting and at the limit, the scan cannot
   // pick the owner because the owner is last and others are requesting.
   always_comb begin
      any_req    = |req;
      owner_req  = gnt_valid & req[gnt_id];
      others_req = |(req & ~gnt);
      expire_now = at_limit & owner_req & others_req;
      take_new   = (~owner_req & any_req) | expire_now;
      go_idle    = ~owner_req & ~any_req;
   end

   // Hold counter only exists when a hold limit is configured. It counts the
   // cycles the current owner has had the grant and saturates at the limit,
   // so a sole requester stays at the limit until someone else shows up.
   generate
      if (MAX_HOLD > 0) begin : g_hold
         localparam int HCW = $clog2(MAX_HOLD + 1);
         logic [HCW-1:0] hold_cnt;

         // Track how long the current owner has held the grant.
         always_ff @(posedge clk) begin
            if (rst) begin
               hold_cnt <= '0;
            end else if (take_new) begin
               hold_cnt <= HCW'(1);
            end else if (go_idle) begin
               hold_cnt <= '0;
            end else if (owner_req && (hold_cnt != HCW'(MAX_HOLD))) begin
               hold_cnt <= hold_cnt + HCW'(1);
            end
         end

         assign at_limit = (hold_cnt == HCW'(MAX_HOLD));
      end else begin : g_no_hold
         assign at_limit = 1'b0;
      end
   endgenerate

   // Registered grant state; last moves only when a new grant is issued,
   // and reset points it at N-1 so requester 0 is first in line.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
         expired   <= 1'b0;
         last      <= IDW'(N - 1);
      end else begin
         expired <= expire_now;
         if (take_new) begin
            gnt       <= winner_onehot;
            gnt_valid <= 1'b1;
            gnt_id    <= winner;
            last      <= winner;
         end else if (go_idle) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: directed vector table and corner sequences for the
// round-robin arbiter, plus a randomised property scoreboard for N=7.

module tb_rr_arbiter_n;

   logic clk;

   logic       rst0, rst1, rst2;
   logic [3:0] req0, req1;
   logic [6:0] req2;

   logic [3:0] gnt0, gnt1;
   logic [6:0] gnt2;
   logic       gv0, gv1, gv2;
   logic [1:0] id0, id1;
   logic [2:0] id2;
   logic       ex0, ex1, ex2;

   int tests_run;
   int fail_count;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       expd;
   } vec_t;

   vec_t vecs [27];

   rr_arbiter_n #(.N(4), .MAX_HOLD(0)) u_dut0 (
      .clk(clk), .rst(rst0), .req(req0),
      .gnt(gnt0), .gnt_valid(gv0), .gnt_id(id0), .expired(ex0)
   );

   rr_arbiter_n #(.N(4), .MAX_HOLD(4)) u_dut1 (
      .clk(clk), .rst(rst1), .req(req1),
      .gnt(gnt1), .gnt_valid(gv1), .gnt_id(id1), .expired(ex1)
   );

   rr_arbiter_n #(.N(7), .MAX_HOLD(0)) u_dut2 (
      .clk(clk), .rst(rst2), .req(req2),
      .gnt(gnt2), .gnt_valid(gv2), .gnt_id(id2), .expired(ex2)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one of the 4-requester arbiters for one edge, then settle.
   task automatic applyStimulus(input int dut, input logic r, input logic [3:0] rq);
      if (dut == 0) begin
         rst0 = r;
         req0 = rq;
      end else begin
         rst1 = r;
         req1 = rq;
      end
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Check all four outputs of a 4-requester arbiter in one go.
   task automatic checkFour(input string tag, input logic [3:0] g, input logic v,
                            input logic [1:0] id, input logic ex,
                            input logic [3:0] eg, input logic [1:0] eid, input logic eex);
      checkOutput({tag, "_gnt"}, 32'(g), 32'(eg));
      checkOutput({tag, "_valid"}, 32'(v), 32'(|eg));
      checkOutput({tag, "_id"}, 32'(id), 32'(eid));
      checkOutput({tag, "_expired"}, 32'(ex), 32'(eex));
   endtask

   initial begin
      logic [6:0] prev_gnt;
      logic [6:0] sampled;
      int         wait_cnt [7];
      int         exp_idx;
      int         owner;
      logic       exp_ex;

      tests_run  = 0;
      fail_count = 0;
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      req0 = '0;   req1 = '0;   req2 = '0;

      // rst, req, expected gnt, expected id, expected expired
      vecs = '{
         '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0},
         '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0},
         '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0},
         '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0},
         '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b0},
         '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b0},
         '{1'b0, 4'b1100, 4'b0100, 2'd2, 1'b0},
         '{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b0},
         '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b0},
         '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0},
         '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0},
         '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0},
         '{1'b0, 4'b0110, 4'b0100, 2'd2, 1'b0},
         '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0},
         '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0},
         '{1'b1, 4'b1010, 4'b0000, 2'd0, 1'b0},
         '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b0},
         '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0},
         '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0},
         '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0},
         '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b0},
         '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b0},
         '{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b0},
         '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b0},
         '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b0},
         '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b0},
         '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b0}
      };

      // Table-driven vectors on the unlimited-hold arbiter.
      for (int i = 0; i < 27; i++) begin
         applyStimulus(0, vecs[i].rst, vecs[i].req);
         checkFour($sformatf("vec%0d", i), gnt0, gv0, id0, ex0,
                   vecs[i].gnt, vecs[i].id, vecs[i].expd);
      end
      rst0 = 1'b1;

      // Hold limit of 4 with two constant requesters: 4 cycles each,
      // expired pulses on the first cycle of every forced handover.
      applyStimulus(1, 1'b1, 4'b0011);
      checkFour("h4_reset", gnt1, gv1, id1, ex1, 4'b0000, 2'd0, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         applyStimulus(1, 1'b0, 4'b0011);
         owner  = ((k - 1) / 4) % 2;
         exp_ex = (k > 1) && (((k - 1) % 4) == 0);
         checkFour($sformatf("h4_rot%0d", k), gnt1, gv1, id1, ex1,
                   4'(1 << owner), 2'(owner), exp_ex);
      end

      // Mid-grant reset while requester 3 owns the bus.
      applyStimulus(1, 1'b1, 4'b0000);
      applyStimulus(1, 1'b0, 4'b1000);
      checkFour("mid_pre", gnt1, gv1, id1, ex1, 4'b1000, 2'd3, 1'b0);
      applyStimulus(1, 1'b1, 4'b1001);
      checkFour("mid_rst", gnt1, gv1, id1, ex1, 4'b0000, 2'd0, 1'b0);
      applyStimulus(1, 1'b0, 4'b1001);
      checkFour("mid_post", gnt1, gv1, id1, ex1, 4'b0001, 2'd0, 1'b0);

      // Sole requester past the hold limit keeps the grant, then rotates
      // as soon as a competitor appears.
      applyStimulus(1, 1'b1, 4'b0000);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1, 1'b0, 4'b0100);
         checkFour($sformatf("sole%0d", k), gnt1, gv1, id1, ex1, 4'b0100, 2'd2, 1'b0);
      end
      applyStimulus(1, 1'b0, 4'b0101);
      checkFour("sole_rot", gnt1, gv1, id1, ex1, 4'b0001, 2'd0, 1'b1);
      applyStimulus(1, 1'b0, 4'b0101);
      checkFour("sole_after", gnt1, gv1, id1, ex1, 4'b0001, 2'd0, 1'b0);
      rst1 = 1'b1;

      // Randomised N=7 run checked against arbiter properties.
      rst2 = 1'b1;
      req2 = '0;
      @(posedge clk);
      #1;
      checkOutput("n7_reset_gnt", 32'(gnt2), 32'd0);
      rst2     = 1'b0;
      prev_gnt = '0;
      for (int i = 0; i < 7; i++) wait_cnt[i] = 0;

      for (int c = 0; c < 10000; c++) begin
         for (int b = 0; b < 7; b++) begin
            if ($urandom_range(0, 3) == 0) req2[b] = ~req2[b];
         end
         sampled = req2;
         @(posedge clk);
         #1;

         exp_idx = 0;
         for (int b = 0; b < 7; b++) begin
            if (gnt2[b]) exp_idx = b;
         end
         checkOutput("n7_onehot", 32'($onehot0(gnt2)), 32'd1);
         checkOutput("n7_valid", 32'(gv2), 32'(|gnt2));
         checkOutput("n7_id", 32'(id2), 32'(exp_idx));
         checkOutput("n7_busy", 32'(gv2), 32'(|sampled));
         checkOutput("n7_expired", 32'(ex2), 32'd0);

         if (gnt2 != prev_gnt && gnt2 != 7'd0) begin
            checkOutput("n7_grant_req", 32'(|(gnt2 & sampled)), 32'd1);
            for (int b = 0; b < 7; b++) begin
               if (gnt2[b] || !sampled[b]) wait_cnt[b] = 0;
               else wait_cnt[b]++;
               checkOutput($sformatf("n7_starve%0d", b), 32'(wait_cnt[b] > 7), 32'd0);
            end
         end else begin
            for (int b = 0; b < 7; b++) begin
               if (!sampled[b]) wait_cnt[b] = 0;
            end
         end
         prev_gnt = gnt2;
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
Parametrised round-robin arbiter for N requesters with registered one-hot grant, binary grant index, and an optional maximum-hold limit that forces rotation when other requesters are waiting. A requester keeps its grant while its request stays high, up to the hold limit. Fair rotating priority: the most recent winner always becomes lowest priority. Drop-in successor for the fixed 4-requester arbiter on shared-bus and shared-resource access paths.

Parameters:
N, 4, number of requesters; legal range 2..32; elaboration error outside range
MAX_HOLD, 0, maximum consecutive cycles one grant may be held while others request; 0 = unlimited
IDW, $clog2(N), width of gnt_id (derived; not to be overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req  in  N  request vector; bit i = requester i
gnt  out  N  registered one-hot grant; all-zero when idle
gnt_valid  out  1  registered; equals |gnt
gnt_id  out  IDW  registered binary index of the granted requester; 0 when idle
expired  out  1  registered one-cycle pulse; grant was taken away by the hold limit

Behaviour:
- Reset (rst high at posedge): gnt=0, gnt_valid=0, gnt_id=0, expired=0, hold_cnt=0, last pointer=N-1 so requester 0 has top priority first.
- State: last pointer (IDW bits), registered gnt/gnt_id, hold_cnt (width $clog2(MAX_HOLD+1), absent when MAX_HOLD=0).
- Arbitration (combinational): scan i=1..N from index (last+i) mod N; first set req bit wins. The scan includes last itself, checked last, so a sole requester can be re-granted.
- Per posedge, with owner = current gnt_id when gnt_valid=1:
  - Idle (gnt_valid=0): any req set -> grant the scan winner, last<=winner, hold_cnt<=1. No req -> stay idle.
  - Hold: req[owner]=1 and not expiring -> gnt unchanged, hold_cnt increments, saturating at MAX_HOLD.
  - Release: req[owner]=0 -> re-arbitrate in the same edge. New winner granted with no dead cycle, or go idle if req=0.
  - Expire: MAX_HOLD>0, hold_cnt==MAX_HOLD, req[owner]=1, and some other req bit set -> grant the scan winner, which cannot be owner because owner is last; expired<=1; hold_cnt<=1.
  - Expire condition met but owner is the sole requester -> owner keeps the grant, hold_cnt stays at MAX_HOLD, expired=0. Rotation happens on the first cycle another request appears.
- Latency: request sampled at edge k -> gnt visible after edge k (1 cycle). Grant handover on release or expiry takes 1 edge.
- gnt is always one-hot or zero. gnt_id and gnt_valid always agree with gnt.
- last updates only when a new grant is issued, including a re-grant after release. It does not change while holding or idle.
- expired is high for exactly one cycle per forced rotation; 0 otherwise.
- Reset asserted mid-grant: all outputs clear at that edge and priority restarts at requester 0.
- Requests arriving while another requester holds the grant wait; no queueing beyond the level-sensitive req.

Test Plan:
- Reset then req=4'b1111 held, MAX_HOLD=0 -> gnt=0001 after first edge and held indefinitely; drop req0 -> next edge gnt=0010, gnt_id=1.
- N=4, MAX_HOLD=0: each requester asserts req for 2 cycles then drops, all always re-requesting -> grant sequence 0,1,2,3,0 with no idle cycle between grants.
- N=4, MAX_HOLD=4, req=4'b0011 constant -> gnt0 for 4 cycles, expired pulse, gnt1 for 4 cycles, expired pulse, repeat.
- MAX_HOLD=4, only req2 high for 10 cycles -> gnt=0100 for all 10 cycles, expired never asserts; req0 rises at cycle 10 -> next edge gnt=0001, expired=1.
- Mid-grant rst pulse while gnt=1000 with req=4'b1001 -> outputs zero during reset; first edge after rst deasserts -> gnt=0001.
- N=7, MAX_HOLD=0, random req for 10k cycles -> scoreboard checks one-hot grant, no starvation beyond N grants for a requester held high, and gnt_id==index of gnt.
